fx_mult_stage: RTL and testbench

FX_MULT_STAGE -- requirements
Module: fx_mult_stage

---
 rtl/fx_pkg.sv | 49 ++++
 rtl/fx_mult_stage_if.sv | 25 ++
 rtl/fx_round_sat.sv | 22 ++
 rtl/fx_mult_stage.sv | 81 ++++++++
 tb/tb_fx_mult_stage.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fx_pkg.sv
// Shared fixed-point definitions: default Q-format and the round-and-saturate helper.
package fx_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 16;
    localparam int unsigned FRAC_BITS_DEF  = DATA_WIDTH_DEF - 1;

    localparam logic [DATA_WIDTH_DEF-1:0] Q_MAX = {1'b0, {(DATA_WIDTH_DEF-1){1'b1}}};
    localparam logic [DATA_WIDTH_DEF-1:0] Q_MIN = {1'b1, {(DATA_WIDTH_DEF-1){1'b0}}};

    // Widest supported operand; the helper works at this width and callers truncate.
    localparam int unsigned MAX_W = 32;
    localparam int unsigned RW    = 2 * MAX_W + 1;

    typedef logic signed [RW-1:0] wide_t;
    localparam wide_t W_ONE = wide_t'(1);

    typedef struct packed {
        logic             sat;
        logic [MAX_W-1:0] val;
    } rs_t;

    // Round half up, arithmetic shift by fb, clamp to a dw-bit signed range.
    function automatic rs_t round_sat(input logic signed [2*MAX_W-1:0] prod,
                                      input int unsigned dw,
                                      input int unsigned fb);
        wide_t r;
        wide_t hi;
        wide_t lo;
        rs_t   o;
        r = {prod[2*MAX_W-1], prod};
        if (fb != 0) begin
            r = r + (W_ONE <<< (fb - 1));
        end
        r  = r >>> fb;
        hi = (W_ONE <<< (dw - 1)) - W_ONE;
        lo = -(W_ONE <<< (dw - 1));
        o.sat = 1'b0;
        o.val = r[MAX_W-1:0];
        if (r > hi) begin
            o.sat = 1'b1;
            o.val = hi[MAX_W-1:0];
        end else if (r < lo) begin
            o.sat = 1'b1;
            o.val = lo[MAX_W-1:0];
        end
        return o;
    endfunction

endpackage

// File: rtl/fx_mult_stage_if.sv
// Operand/result handshake bundle of the fixed-point multiplier stage.
interface fx_mult_stage_if import fx_pkg::*; #(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) ();

    logic [DATA_WIDTH-1:0] a_in;
    logic [DATA_WIDTH-1:0] b_in;
    logic                  valid_in;
    logic                  ready_o;
    logic [DATA_WIDTH-1:0] res_o;
    logic                  valid_o;
    logic                  ready_in;
    logic                  sat_o;

    modport master (
        output a_in, b_in, valid_in, ready_in,
        input  ready_o, res_o, valid_o, sat_o
    );

    modport slave (
        input  a_in, b_in, valid_in, ready_in,
        output ready_o, res_o, valid_o, sat_o
    );

endinterface

// File: rtl/fx_round_sat.sv
// Combinational round-half-up and saturate from a full-width product to DATA_WIDTH.
module fx_round_sat import fx_pkg::*; #(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned FRAC_BITS  = DATA_WIDTH - 1
) (
    input  logic signed [2*DATA_WIDTH-1:0] i_prod,
    output logic        [DATA_WIDTH-1:0]   o_res,
    output logic                           o_sat
);

    rs_t  w_rs;
    logic w_unused_hi;

    always_comb begin
        w_rs = round_sat((2*MAX_W)'(i_prod), DATA_WIDTH, FRAC_BITS);
    end

    assign o_res       = w_rs.val[DATA_WIDTH-1:0];
    assign o_sat       = w_rs.sat;
    assign w_unused_hi = ^(w_rs.val >> DATA_WIDTH);

endmodule

// File: rtl/fx_mult_stage.sv
// Three-stage signed fixed-point multiplier with a single global stall and saturation counter.
module fx_mult_stage import fx_pkg::*; #(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned FRAC_BITS  = DATA_WIDTH - 1
) (
    input  logic           clk_in,
    input  logic           rst_in,
    fx_mult_stage_if.slave mul_if,
    input  logic           clr_cnt_in,
    output logic [15:0]    sat_cnt_o
);

    logic                           w_en;
    logic                           w_xfer_sat;
    logic        [DATA_WIDTH-1:0]   w_res;
    logic                           w_sat;

    logic                           r_v1;
    logic                           r_v2;
    logic                           r_v3;
    logic signed [DATA_WIDTH-1:0]   r_a;
    logic signed [DATA_WIDTH-1:0]   r_b;
    logic signed [2*DATA_WIDTH-1:0] r_prod;
    logic        [DATA_WIDTH-1:0]   r_res;
    logic                           r_sat;
    logic        [15:0]             r_cnt;

    // The whole pipe freezes only when the output slot is full and not taken.
    assign w_en       = !r_v3 || mul_if.ready_in;
    assign w_xfer_sat = r_v3 && mul_if.ready_in && r_sat;

    assign mul_if.ready_o = w_en;
    assign mul_if.valid_o = r_v3;
    assign mul_if.res_o   = r_res;
    assign mul_if.sat_o   = r_sat;
    assign sat_cnt_o      = r_cnt;

    fx_round_sat #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS)
    ) u_round_sat (
        .i_prod (r_prod),
        .o_res  (w_res),
        .o_sat  (w_sat)
    );

    always_ff @(posedge clk_in) begin
        if (w_en) begin
            r_a    <= mul_if.a_in;
            r_b    <= mul_if.b_in;
            r_prod <= (2*DATA_WIDTH)'(r_a) * (2*DATA_WIDTH)'(r_b);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_v1  <= 1'b0;
            r_v2  <= 1'b0;
            r_v3  <= 1'b0;
            r_res <= '0;
            r_sat <= 1'b0;
        end else if (w_en) begin
            r_v1  <= mul_if.valid_in;
            r_v2  <= r_v1;
            r_v3  <= r_v2;
            r_res <= w_res;
            r_sat <= w_sat;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_cnt <= '0;
        end else if (clr_cnt_in) begin
            r_cnt <= {15'd0, w_xfer_sat};
        end else if (w_xfer_sat && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_fx_mult_stage.sv
// Bench for fx_mult_stage: directed vector table, stall/reset/clear sequences, random stream vs real-valued model.
module tb_fx_mult_stage;

    localparam int DW = 16;
    localparam int FB = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic [15:0] sat_cnt;

    fx_mult_stage_if #(.DATA_WIDTH(DW)) mif ();

    fx_mult_stage #(
        .DATA_WIDTH (DW),
        .FRAC_BITS  (FB)
    ) dut (
        .clk_in     (clk),
        .rst_in     (rst),
        .mul_if     (mif),
        .clr_cnt_in (clr),
        .sat_cnt_o  (sat_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        sat;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    vec_t        vecs[8];
    logic [15:0] q_res[$];
    logic        q_sat[$];
    int          exp_cnt;
    int          delivered;
    logic        stall_prev;
    logic [15:0] hold_res;
    logic        hold_sat;
    logic        last_acc;

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Reference: exact real product, floor(x + 0.5), clamp to the signed range.
    function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] r, output logic s);
        longint p;
        real    q;
        longint qi;
        longint hi;
        longint lo;
        p  = longint'($signed(a)) * longint'($signed(b));
        q  = $floor(real'(p) / (2.0 ** FB) + 0.5);
        qi = longint'($rtoi(q));
        hi = (longint'(1) << (DW - 1)) - 1;
        lo = -(longint'(1) << (DW - 1));
        s  = 1'b0;
        if (qi > hi) begin
            s  = 1'b1;
            qi = hi;
        end else if (qi < lo) begin
            s  = 1'b1;
            qi = lo;
        end
        r = qi[15:0];
    endfunction

    function automatic logic [15:0] rnd_op();
        logic [15:0] ext[6];
        int          k;
        ext = '{16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF, 16'h4000, 16'h0001};
        k   = int'($urandom_range(0, 5));
        if ($urandom_range(0, 3) == 0) return ext[k];
        return 16'($urandom);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called with this cycle's inputs already driven; checks, updates the model, advances one clock.
    task automatic cycle_check();
        logic [15:0] er;
        logic        es;
        logic        xs;
        #1;
        chk1("ready_o", mif.ready_o, !(mif.valid_o && !mif.ready_in));
        if (stall_prev) begin
            chk1("hold_valid", mif.valid_o, 1'b1);
            chk16("hold_res", mif.res_o, hold_res);
            chk1("hold_sat", mif.sat_o, hold_sat);
        end
        chk16("sat_cnt", sat_cnt, 16'(exp_cnt));
        last_acc = mif.valid_in && mif.ready_o;
        if (last_acc) begin
            model(mif.a_in, mif.b_in, er, es);
            q_res.push_back(er);
            q_sat.push_back(es);
        end
        xs = 1'b0;
        if (mif.valid_o && mif.ready_in) begin
            if (q_res.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got valid_o=1 res=%h, expected no pending result", mif.res_o);
            end else begin
                er = q_res.pop_front();
                es = q_sat.pop_front();
                chk16("res_o", mif.res_o, er);
                chk1("sat_o", mif.sat_o, es);
                xs = es;
                delivered++;
            end
        end
        if (clr) exp_cnt = xs ? 1 : 0;
        else if (xs && exp_cnt < 65535) exp_cnt++;
        stall_prev = mif.valid_o && !mif.ready_in;
        hold_res   = mif.res_o;
        hold_sat   = mif.sat_o;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        clr          = 1'b0;
        mif.valid_in = 1'b0;
        mif.ready_in = 1'b0;
        step();
        step();
        rst = 1'b0;
        q_res.delete();
        q_sat.delete();
        exp_cnt    = 0;
        delivered  = 0;
        stall_prev = 1'b0;
        last_acc   = 1'b0;
    endtask

    initial begin
        int          dcnt;
        int          idx;
        int          n;
        logic        hold;
        logic [15:0] sa[8];
        logic [15:0] sb[8];

        rst          = 1'b1;
        clr          = 1'b0;
        mif.valid_in = 1'b0;
        mif.ready_in = 1'b0;
        mif.a_in     = '0;
        mif.b_in     = '0;
        exp_cnt      = 0;
        delivered    = 0;
        stall_prev   = 1'b0;
        last_acc     = 1'b0;

        vecs[0] = '{16'h4000, 16'h4000, 16'h2000, 1'b0};
        vecs[1] = '{16'h8000, 16'h8000, 16'h7FFF, 1'b1};
        vecs[2] = '{16'h4000, 16'h0001, 16'h0001, 1'b0};
        vecs[3] = '{16'hFFFF, 16'h4000, 16'h0000, 1'b0};
        vecs[4] = '{16'h8000, 16'h7FFF, 16'h8001, 1'b0};
        vecs[5] = '{16'h7FFF, 16'h7FFF, 16'h7FFE, 1'b0};
        vecs[6] = '{16'h8000, 16'h0001, 16'hFFFF, 1'b0};
        vecs[7] = '{16'hC000, 16'h4000, 16'hE000, 1'b0};

        step();
        step();
        chk1("rst_valid_o", mif.valid_o, 1'b0);
        chk16("rst_res_o", mif.res_o, 16'h0000);
        chk1("rst_sat_o", mif.sat_o, 1'b0);
        chk16("rst_sat_cnt", sat_cnt, 16'h0000);
        rst = 1'b0;
        #1;
        chk1("ready_after_release", mif.ready_o, 1'b1);
        step();

        // Directed vectors, one at a time, with exact latency.
        dcnt = 0;
        for (int i = 0; i < 8; i++) begin
            mif.a_in     = vecs[i].a;
            mif.b_in     = vecs[i].b;
            mif.valid_in = 1'b1;
            mif.ready_in = 1'b1;
            step();
            mif.valid_in = 1'b0;
            chk1("lat_cycle1", mif.valid_o, 1'b0);
            step();
            chk1("lat_cycle2", mif.valid_o, 1'b0);
            step();
            chk1("lat_cycle3", mif.valid_o, 1'b1);
            chk16("vec_res", mif.res_o, vecs[i].res);
            chk1("vec_sat", mif.sat_o, vecs[i].sat);
            step();
            if (vecs[i].sat) dcnt++;
            chk16("vec_cnt", sat_cnt, 16'(dcnt));
            chk1("vec_drained", mif.valid_o, 1'b0);
        end

        // Second saturated delivery, then a stalled saturated result released together with clear.
        mif.a_in     = 16'h8000;
        mif.b_in     = 16'h8000;
        mif.valid_in = 1'b1;
        step();
        mif.valid_in = 1'b0;
        step();
        step();
        step();
        chk16("cnt_two", sat_cnt, 16'd2);
        mif.valid_in = 1'b1;
        step();
        mif.valid_in = 1'b0;
        mif.ready_in = 1'b0;
        step();
        step();
        chk1("stall_valid", mif.valid_o, 1'b1);
        chk1("stall_sat", mif.sat_o, 1'b1);
        chk1("stall_ready_o", mif.ready_o, 1'b0);
        step();
        chk1("stall_hold_valid", mif.valid_o, 1'b1);
        chk16("stall_hold_res", mif.res_o, 16'h7FFF);
        chk16("stall_cnt", sat_cnt, 16'd2);
        mif.ready_in = 1'b1;
        clr          = 1'b1;
        step();
        chk16("clr_with_sat_xfer", sat_cnt, 16'd1);
        chk1("clr_xfer_done", mif.valid_o, 1'b0);
        step();
        chk16("clr_plain", sat_cnt, 16'd0);
        clr = 1'b0;

        // Reset with three results in flight.
        for (int k = 0; k < 4; k++) begin
            mif.valid_in = 1'b1;
            step();
        end
        mif.valid_in = 1'b0;
        chk16("pre_reset_cnt", sat_cnt, 16'd1);
        chk1("pre_reset_valid", mif.valid_o, 1'b1);
        rst = 1'b1;
        step();
        chk1("mid_rst_valid_o", mif.valid_o, 1'b0);
        chk16("mid_rst_cnt", sat_cnt, 16'd0);
        chk16("mid_rst_res", mif.res_o, 16'h0000);
        chk1("mid_rst_ready_o", mif.ready_o, 1'b1);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            chk1("no_stale_output", mif.valid_o, 1'b0);
        end

        // Eight back-to-back inputs with the sink stalled in cycles 4-6.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            sa[k] = rnd_op();
            sb[k] = rnd_op();
        end
        idx = 0;
        for (int cyc = 0; cyc < 24; cyc++) begin
            mif.valid_in = (idx < 8);
            if (idx < 8) begin
                mif.a_in = sa[idx];
                mif.b_in = sb[idx];
            end
            mif.ready_in = !(cyc >= 4 && cyc <= 6);
            cycle_check();
            if (last_acc) idx++;
        end
        chk16("stream_delivered", 16'(delivered), 16'd8);
        chk16("stream_pending", 16'(q_res.size()), 16'd0);

        // Random traffic with upstream holding refused data.
        do_reset();
        hold = 1'b0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (!hold) begin
                mif.valid_in = ($urandom_range(0, 3) != 0);
                mif.a_in     = rnd_op();
                mif.b_in     = rnd_op();
            end
            mif.ready_in = ($urandom_range(0, 3) != 0);
            clr          = ($urandom_range(0, 63) == 0);
            cycle_check();
            hold = mif.valid_in && !last_acc;
        end
        mif.valid_in = 1'b0;
        mif.ready_in = 1'b1;
        clr          = 1'b0;
        for (int cyc = 0; cyc < 8; cyc++) cycle_check();
        chk16("random_pending", 16'(q_res.size()), 16'd0);

        // Counter ceiling: more than 65535 saturated deliveries.
        do_reset();
        n            = 0;
        mif.a_in     = 16'h8000;
        mif.b_in     = 16'h8000;
        mif.valid_in = 1'b1;
        mif.ready_in = 1'b1;
        for (int c = 0; c < 65540; c++) begin
            if (n == 65534) chk16("cnt_at_65534", sat_cnt, 16'hFFFE);
            if (n == 65535) chk16("cnt_at_65535", sat_cnt, 16'hFFFF);
            if (mif.valid_o && mif.ready_in) n++;
            step();
        end
        mif.valid_in = 1'b0;
        for (int k = 0; k < 4; k++) step();
        chk16("cnt_no_wrap", sat_cnt, 16'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
